// File: rtl/pipeline_trace_buffer_if.sv
// Bus bundle for pipeline_trace_buffer: capture control, lane samples, readout and status.
// The master modport drives the tracer; the slave modport is the tracer itself.
interface pipeline_trace_buffer_if #(
    parameter int NUM_LANES = 2,
    parameter int CODE_W    = 4,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = TS_W + NUM_LANES * (CODE_W + 1);

    logic                        arm;
    logic                        abort;
    logic [NUM_LANES-1:0]        lane_vld;
    logic [NUM_LANES*CODE_W-1:0] lane_code;
    logic [CODE_W-1:0]           trig_code;
    logic [NUM_LANES-1:0]        trig_mask;
    logic                        rd_en;
    logic [AW-1:0]               rd_idx;
    logic [ENTRY_W-1:0]          rd_data;
    logic                        rd_vld;
    logic [1:0]                  state;
    logic [AW:0]                 count;
    logic [AW-1:0]               trig_ptr;
    logic                        overflow;

    modport master (
        output arm, abort, lane_vld, lane_code, trig_code, trig_mask, rd_en, rd_idx,
        input  rd_data, rd_vld, state, count, trig_ptr, overflow
    );

    modport slave (
        input  arm, abort, lane_vld, lane_code, trig_code, trig_mask, rd_en, rd_idx,
        output rd_data, rd_vld, state, count, trig_ptr, overflow
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular trace buffer of per-lane pipeline event codes with timestamp, trigger and post-trigger window.
// Optional TRACE_DEDUP_EN: drop samples identical to the last stored entry (trigger entry always kept).
module pipeline_trace_buffer #(
    parameter int NUM_LANES = 2,
    parameter int CODE_W    = 4,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int SAMPLE_W = NUM_LANES * (CODE_W + 1);
    localparam int ENTRY_W  = TS_W + SAMPLE_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [AW-1:0]      trig_ptr_q, trig_ptr_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] rd_data_q;
    logic               rd_vld_q;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] sample;
    logic               capturing;
    logic               arm_go;
    logic               trig_hit;
    logic               dup;
    logic               wr_en;
    logic [AW-1:0]      rd_addr;
    logic               rd_in_range;

    assign sample    = {bus.lane_code, bus.lane_vld};
    assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
    assign arm_go    = !bus.abort && bus.arm && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        trig_hit = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.lane_vld[i] && bus.trig_mask[i] &&
                (bus.lane_code[i*CODE_W +: CODE_W] == bus.trig_code))
                trig_hit = 1'b1;
        end
        if (state_q != S_ARMED)
            trig_hit = 1'b0;
    end

`ifdef TRACE_DEDUP_EN
    logic [SAMPLE_W-1:0] last_q;
    logic                last_vld_q;

    assign dup = last_vld_q && (sample == last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (arm_go) begin
            last_vld_q <= 1'b0;
        end else if (wr_en) begin
            last_q     <= sample;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        trig_ptr_d = trig_ptr_q;
        ts_d       = ts_q;
        post_cnt_d = post_cnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else if (arm_go) begin
            state_d    = S_ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            ts_d       = '0;
            overflow_d = 1'b0;
        end else if (capturing) begin
            ts_d = ts_q + 1'b1;
            if (|bus.lane_vld && (trig_hit || !dup)) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q == FULL)
                    overflow_d = 1'b1;
                else
                    count_d = count_q + 1'b1;

                if (trig_hit) begin
                    trig_ptr_d = wr_ptr_q;
                    if (POST_TRIG == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_POST;
                        post_cnt_d = AW'(POST_TRIG);
                    end
                end else if (state_q == S_POST) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == AW'(1))
                        state_d = S_DONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            trig_ptr_q <= '0;
            ts_q       <= '0;
            post_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            trig_ptr_q <= trig_ptr_d;
            ts_q       <= ts_d;
            post_cnt_q <= post_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the trace RAM has no reset; count bounds what readout can expose, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= {ts_q, sample};
    end

    // Oldest entry sits count positions behind wr_ptr; a full buffer wraps to wr_ptr itself.
    assign rd_addr     = wr_ptr_q - count_q[AW-1:0] + bus.rd_idx;
    assign rd_in_range = {1'b0, bus.rd_idx} < count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= bus.rd_en;
            if (bus.rd_en)
                rd_data_q <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_vld   = rd_vld_q;
    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.trig_ptr = trig_ptr_q;
    assign bus.overflow = overflow_q;
endmodule
